// File: rtl/seq_array_divider_if.sv
// seq_array_divider_if: start/busy/done handshake and operand/result bundle for the divider
interface seq_array_divider_if #(parameter int WIDTH = 4);
  logic               start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;
  logic               overflow;
  modport master (output start, dividend, divisor,
                  input busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave  (input start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/seq_array_divider.sv
// seq_array_divider: restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock
module seq_array_divider #(parameter int WIDTH = 4) (
  input  logic               clk,
  input  logic               rst_n,
  seq_array_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_nx;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] low_r;
  logic [WIDTH-1:0] dsr_r;
  logic [CW-1:0]    cnt;
  logic             err;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic             zero_d;
  logic             ovf_d;
  logic             accept;
  assign zero_d  = bus.divisor == '0;
  assign ovf_d   = bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor;
  assign accept  = state == IDLE && bus.start;
  assign shifted = {rem_r[WIDTH-1:0], low_r[WIDTH-1]};
  assign fits    = shifted >= {1'b0, dsr_r};
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = (zero_d || ovf_d) ? FINISH : CALC;
    else if (state == CALC && cnt == CW'(WIDTH-1)) state_nx = FINISH;
    else if (state == FINISH) state_nx = IDLE;
  end
  // low_r holds the unconsumed dividend bits and collects quotient bits from the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r           <= '0;
      low_r           <= '0;
      dsr_r           <= '0;
      cnt             <= '0;
      err             <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= state == FINISH;
      if (accept) begin
        rem_r           <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
        low_r           <= bus.dividend[WIDTH-1:0];
        dsr_r           <= bus.divisor;
        cnt             <= '0;
        err             <= zero_d || ovf_d;
        bus.div_by_zero <= zero_d;
        bus.overflow    <= !zero_d && ovf_d;
      end else if (state == CALC) begin
        rem_r <= fits ? shifted - {1'b0, dsr_r} : shifted;
        low_r <= {low_r[WIDTH-2:0], fits};
        cnt   <= cnt + 1'b1;
      end else if (state == FINISH) begin
        bus.quotient  <= err ? '1 : low_r;
        bus.remainder <= err ? low_r : rem_r[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_seq_array_divider.sv
// tb_seq_array_divider: table vectors, hand sequences and exhaustive sweep, scoreboarded by done pulses
module tb_seq_array_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  seq_array_divider_if #(.WIDTH(4)) bus ();
  seq_array_divider #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    int         cyc;
    string      nm;
  } exp_t;
  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic issue(input logic [7:0] dd, input logic [3:0] dv, input logic [3:0] q,
                       input logic [3:0] r, input logic dz, input logic ov, input string nm);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.nm = nm;
    e.cyc = cyc + 1 + ((dz || ov) ? 1 : 5);
    sb.push_back(e);
    bus.start = 1'b1;
    bus.dividend = dd;
    bus.divisor = dv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor = 4'($urandom);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask
  task automatic model(input int dd, input int dv);
    int q;
    logic [3:0] qq, rr;
    logic ov;
    q  = dd / dv;
    ov = q > 15;
    qq = ov ? 4'hF : 4'(q);
    rr = ov ? 4'(dd) : 4'(dd % dv);
    issue(8'(dd), 4'(dv), qq, rr, 1'b0, ov, "sweep");
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_q"}, bus.quotient, e.q);
        chk({e.nm, "_r"}, bus.remainder, e.r);
        chk({e.nm, "_dz"}, bus.div_by_zero, e.dz);
        chk({e.nm, "_ov"}, bus.overflow, e.ov);
        chk({e.nm, "_latency"}, cyc, e.cyc);
        chk({e.nm, "_busy_low"}, bus.busy, 0);
      end
    end
  end
  initial begin
    int busy_cnt;
    bit saw_done;
    vecs[0] = '{8'd81,  4'd9,  4'd9,  4'd0,  1'b0, 1'b0};
    vecs[1] = '{8'd110, 4'd11, 4'd10, 4'd0,  1'b0, 1'b0};
    vecs[2] = '{8'd200, 4'd5,  4'd15, 4'd8,  1'b0, 1'b1};
    vecs[3] = '{8'd37,  4'd0,  4'd15, 4'd5,  1'b1, 1'b0};
    vecs[4] = '{8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0};
    vecs[5] = '{8'd255, 4'd15, 4'd15, 4'd15, 1'b0, 1'b1};
    vecs[6] = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0};
    vecs[7] = '{8'd0,   4'd1,  4'd0,  4'd0,  1'b0, 1'b0};
    vecs[8] = '{8'd0,   4'd0,  4'd15, 4'd0,  1'b1, 1'b0};
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    chk("rst_ov", bus.overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd120, 4'd15, 4'd8, 4'd0, 1'b0, 1'b0, "d120_15");
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 5);
    wait_idle();
    foreach (vecs[i]) begin
      issue(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov, $sformatf("vec%0d", i));
      wait_idle();
    end
    issue(8'd81, 4'd9, 4'd9, 4'd0, 1'b0, 1'b0, "b2b_first");
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    #1;
    issue(8'd110, 4'd11, 4'd10, 4'd0, 1'b0, 1'b0, "b2b_second");
    chk("b2b_busy_again", bus.busy, 1);
    wait_idle();
    issue(8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, "ignored_start");
    @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor = 4'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    issue(8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, "reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_q", bus.quotient, 0);
    chk("midrst_r", bus.remainder, 0);
    chk("midrst_dz", bus.div_by_zero, 0);
    chk("midrst_ov", bus.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);
    for (int dd = 0; dd < 256; dd++)
      for (int dv = 1; dv < 16; dv++) begin
        model(dd, dv);
        wait_idle();
      end
    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_array_divider.md
Name: seq_array_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's 4x4 array multiplier.
- Takes a 2*WIDTH-bit dividend (a product) and a WIDTH-bit divisor. Returns WIDTH-bit quotient and remainder, one quotient bit per clock.
- Uses a start/busy/done handshake. It sits beside the multiplier in the arithmetic datapath and lets product/factor round-trip checks run in hardware.

Parameters:
- WIDTH, 4, operand width. Dividend is 2*WIDTH bits; divisor, quotient and remainder are WIDTH bits. Legal range is 2 to 16.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only while the block is idle.
- dividend  input  2*WIDTH  numerator; captured on the accepting edge.
- divisor  input  WIDTH  denominator; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from that cycle on.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  status of the last operation: divisor was 0.
- overflow  output  1  status of the last operation: quotient does not fit in WIDTH bits.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, div_by_zero and overflow all 0; quotient and remainder 0; step counter 0. Reset mid-operation abandons the division, and no done pulse follows.
- FSM states: IDLE, CALC, FINISH.
- IDLE -> CALC on an edge with start=1:
  - latch dividend and divisor;
  - clear div_by_zero and overflow;
  - busy becomes 1.
- IDLE -> FINISH on a start edge where an error is detected at capture:
  - divisor == 0: div_by_zero=1 (takes priority over overflow).
  - else dividend[2W-1:W] >= divisor: overflow=1.
  - In both cases busy becomes 1 for exactly one cycle.
- CALC performs one restoring step per edge, MSB first, for WIDTH edges:
  - partial remainder R is WIDTH+1 bits, initialised from dividend[2W-1:W];
  - shift R left, bringing in the next low-dividend bit;
  - if R >= divisor: R = R - divisor and the quotient bit is 1; otherwise the quotient bit is 0;
  - after WIDTH steps, go to FINISH.
- FINISH -> IDLE on the next edge:
  - quotient and remainder registers update;
  - done=1 for that one cycle; busy=0.
- On error, FINISH outputs quotient = all ones and remainder = dividend[W-1:0].
- Latency:
  - normal case: start edge E0, done high after edge E(WIDTH+1);
  - error case: done high after E1.
- start while busy is ignored and does not queue.
- start in the cycle done is high is accepted, allowing back-to-back operation with no idle gap.
- Operands may change freely after the accepting edge.
- quotient, remainder and the status flags are stable from done until the next accepted start. At that start edge the flags clear; quotient and remainder keep their old values until the next FINISH.
- Normal-case invariant: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Reset, then WIDTH=4, dividend=120, divisor=15, start pulse -> busy high 5 cycles; done after 5 edges; quotient=8, remainder=0, both flags 0.
- dividend=81, divisor=9, then on the done cycle start with dividend=110, divisor=11 -> q=9 r=0, then back-to-back q=10 r=0 with no idle cycle between the two busy periods.
- dividend=200, divisor=5 -> done after 1 edge; overflow=1, div_by_zero=0, quotient=15, remainder=8.
- divisor=0, dividend=37 -> done after 1 edge; div_by_zero=1, overflow=0, quotient=15, remainder=5.
- Start 100/7; pulse start again at cycle 2 with 50/5; then assert rst_n low at cycle 3 of a fresh 100/7 run.
  - The second start is ignored: first result q=14 r=2.
  - After reset: all outputs 0, no done pulse.
- Exhaustive sweep: all dividends 0..255 against divisors 1..15, checked against a reference model.
  - Quotient, remainder and overflow match the model on every case.
  - Latency is 5 cycles, or 1 on overflow.
